ifetch_bus_ctrl: RTL and testbench
==================================

// Module: ifetch_bus_ctrl
// PURPOSE
//   Instruction-bus front end of the fetch stage.
//   - Owns the architectural fetch PC and issues one ibus request at a time.
//   - Tracks the request through address phase (addr_ok) and data phase (data_ok).
//   - Holds the returned instruction until the fetch/decode side accepts it.
//   - Squashes in-flight responses when a branch or flush redirects the PC.
//   Sits between the memory ibus port and the fetch pipeline register that feeds decode.
// PARAMETERS
//   RESET_PC  64'h8000_0000  PC loaded on reset
//   ADDR_W    64             PC / bus address width
//   INSTR_W   32             instruction / ibus data width
// PORTS
//   clk            in   1        clock; all state updates on posedge
//   reset          in   1        synchronous, active-high reset
//   redirect       in   1        branch/flush: refetch from redirect_pc
//   redirect_pc    in   ADDR_W   redirect target
//   ireq_valid     out  1        ibus request valid
//   ireq_addr      out  ADDR_W   ibus request address
//   iresp_addr_ok  in   1        ibus accepted the address this cycle
//   iresp_data_ok  in   1        ibus returns data this cycle
//   iresp_data     in   INSTR_W  ibus read data
//   out_valid      out  1        instruction available to the fetch register
//   out_ready      in   1        fetch register accepts the instruction
//   out_pc         out  ADDR_W   PC of the held instruction
//   out_instr      out  INSTR_W  held raw instruction
// BEHAVIOUR
//   State: fsm {REQ, WAIT, HOLD}, pc, instr_q, pend (1b), pend_pc.
//   Reset: fsm=REQ, pc=RESET_PC, pend=0, instr_q=0.
//     While reset is high: ireq_valid=0, out_valid=0.
//     Reset mid-transaction abandons any outstanding response; the ibus slave shares this reset.
//   kill = redirect | pend.  ktgt = redirect ? redirect_pc : pend_pc (newest redirect wins).
//   REQ:  ireq_valid=1, ireq_addr=pc.
//     - Address must stay stable until addr_ok; redirect never withdraws or changes it.
//     - no addr_ok: if redirect, then pend<=1, pend_pc<=redirect_pc.
//     - addr_ok & ~data_ok: ->WAIT. If redirect, set pend as above.
//     - addr_ok & data_ok: handled exactly as WAIT receiving data_ok.
//   WAIT: ireq_valid=0.
//     - ~data_ok: if redirect, set pend as above.
//     - data_ok & kill: drop data, pc<=ktgt, pend<=0, ->REQ.
//     - data_ok & ~kill: instr_q<=iresp_data, ->HOLD.
//   HOLD: ireq_valid=0. out_valid=~redirect; out_pc=pc; out_instr=instr_q.
//     - Outputs stay stable while out_ready=0.
//     - redirect: instruction dropped (no transfer even if out_ready=1); pc<=redirect_pc, ->REQ.
//     - out_ready & ~redirect: transfer; pc<=pc+4, ->REQ.
//   out_valid=0 in REQ/WAIT. pend is never set in HOLD.
//   Arithmetic: pc+4 wraps modulo 2^ADDR_W.
//     No alignment check; misaligned targets pass through to ireq_addr and out_pc.
//   Latency: REQ to out_valid >= 1 cycle (zero-wait bus: req cycle N, out_valid N+1).
//     Maximum throughput: one instruction per 2 cycles.
//   data_ok outside REQ/WAIT is a protocol error: ignored, assertion fires.
// TESTING
//   1. Zero-wait bus (addr_ok=data_ok=1, data=0x00000013), out_ready=1
//      -> req 0x8000_0000 in cycle 1, out_valid cycle 2 with pc 0x8000_0000, next req 0x8000_0004.
//   2. HOLD with out_ready=0 for 5 cycles
//      -> out_valid/out_pc/out_instr stable, ireq_valid=0, no new request.
//   3. addr_ok delayed 3 cycles, redirect to 0x8000_0100 in the 2nd cycle
//      -> ireq_addr held at 0x8000_0000; returned data dropped; next req 0x8000_0100.
//   4. In WAIT, redirect 0x8000_0100 then 0x8000_0200, then data_ok with 0xDEADBEEF
//      -> never on out_instr; next req 0x8000_0200.
//   5. HOLD with out_ready=1 and redirect=1 to 0x8000_0040
//      -> out_valid=0 that cycle, no transfer; next req 0x8000_0040.
//   6. reset pulsed while in WAIT at pc 0x8000_0010
//      -> ireq_valid=0 during reset; first req after reset to 0x8000_0000; pend=0.

Source files
------------

// File: rtl/ifetch_bus_ctrl.sv
// rtl/ifetch_bus_ctrl.sv - instruction-bus front end of the fetch stage
//
// Owns the fetch PC, issues one ibus request at a time, follows it through
// the address phase (addr_ok) and the data phase (data_ok), and holds the
// returned instruction until the fetch register takes it. A redirect
// (branch/flush) squashes any response still in flight.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   i_redirect          refetch from i_redirect_pc
//   i_redirect_pc       redirect target
//   o_ireq_valid        ibus request valid
//   o_ireq_addr         ibus request address
//   i_iresp_addr_ok     ibus accepted the address this cycle
//   i_iresp_data_ok     ibus returns data this cycle
//   i_iresp_data        ibus read data
//   o_out_valid         instruction available to the fetch register
//   i_out_ready         fetch register accepts the instruction
//   o_out_pc            PC of the held instruction
//   o_out_instr         held raw instruction

module ifetch_bus_ctrl #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h8000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_ireq_valid,
  output logic [ADDR_W-1:0]  o_ireq_addr,
  input  logic               i_iresp_addr_ok,
  input  logic               i_iresp_data_ok,
  input  logic [INSTR_W-1:0] i_iresp_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [ADDR_W-1:0]  o_out_pc,
  output logic [INSTR_W-1:0] o_out_instr
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr_q;
  logic               r_pend;
  logic [ADDR_W-1:0]  r_pend_pc;

  logic               w_data_take;
  logic               w_kill;
  logic [ADDR_W-1:0]  w_ktgt;

  // Data is consumed in WAIT, or in REQ when the bus accepts the address
  // and returns data in the same cycle (zero-wait slave).
  assign w_data_take = i_iresp_data_ok &
                       ((r_state == S_WAIT) | ((r_state == S_REQ) & i_iresp_addr_ok));

  // A live redirect this cycle is newer than any remembered one.
  assign w_kill = i_redirect | r_pend;
  assign w_ktgt = i_redirect ? i_redirect_pc : r_pend_pc;

  // The request address is the PC itself, so it cannot move before addr_ok:
  // redirects seen in REQ/WAIT are parked in r_pend instead of touching r_pc.
  assign o_ireq_valid = ~reset & (r_state == S_REQ);
  assign o_ireq_addr  = r_pc;
  assign o_out_valid  = ~reset & (r_state == S_HOLD) & ~i_redirect;
  assign o_out_pc     = r_pc;
  assign o_out_instr  = r_instr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_instr_q <= '0;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      case (r_state)
        S_REQ, S_WAIT: begin
          if (w_data_take) begin
            if (w_kill) begin
              r_pc    <= w_ktgt;
              r_pend  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_instr_q <= i_iresp_data;
              r_state   <= S_HOLD;
            end
          end else begin
            if ((r_state == S_REQ) && i_iresp_addr_ok) begin
              r_state <= S_WAIT;
            end
            if (i_redirect) begin
              r_pend    <= 1'b1;
              r_pend_pc <= i_redirect_pc;
            end
          end
        end
        S_HOLD: begin
          // Redirect drops the held instruction even if out_ready is high.
          if (i_redirect) begin
            r_pc    <= i_redirect_pc;
            r_state <= S_REQ;
          end else if (i_out_ready) begin
            r_pc    <= r_pc + ADDR_W'(4);
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // No response may arrive while an instruction is being held.
  a_no_data_in_hold: assert property (
    @(posedge clk) disable iff (reset) (r_state == S_HOLD) |-> !i_iresp_data_ok
  );

endmodule

// File: tb/tb_ifetch_bus_ctrl.sv
// tb/tb_ifetch_bus_ctrl.sv - self-checking bench for ifetch_bus_ctrl
module tb_ifetch_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic        o_ireq_valid;
  logic [63:0] o_ireq_addr;
  logic        i_iresp_addr_ok;
  logic        i_iresp_data_ok;
  logic [31:0] i_iresp_data;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [63:0] o_out_pc;
  logic [31:0] o_out_instr;

  int n_checks = 0;
  int n_errors = 0;

  ifetch_bus_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .i_redirect      (i_redirect),
    .i_redirect_pc   (i_redirect_pc),
    .o_ireq_valid    (o_ireq_valid),
    .o_ireq_addr     (o_ireq_addr),
    .i_iresp_addr_ok (i_iresp_addr_ok),
    .i_iresp_data_ok (i_iresp_data_ok),
    .i_iresp_data    (i_iresp_data),
    .o_out_valid     (o_out_valid),
    .i_out_ready     (i_out_ready),
    .o_out_pc        (o_out_pc),
    .o_out_instr     (o_out_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: the fetch address in flight, whether the bus
  // has taken it, whether an instruction is being held, and the latest
  // redirect target that arrived while the request was outstanding.
  logic [63:0] m_pc     = 64'h8000_0000;
  logic        m_acc    = 1'b0;
  logic        m_have   = 1'b0;
  logic [31:0] m_instr  = '0;
  logic        m_sq     = 1'b0;
  logic [63:0] m_sq_pc  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 64'h8000_0000; m_acc = 1'b0; m_have = 1'b0; m_sq = 1'b0; m_instr = '0;
    end else if (m_have) begin
      if (i_redirect) begin
        m_pc = i_redirect_pc; m_have = 1'b0;
      end else if (i_out_ready) begin
        m_pc = m_pc + 64'd4; m_have = 1'b0;
      end
    end else if (i_iresp_data_ok && (m_acc || i_iresp_addr_ok)) begin
      m_acc = 1'b0;
      if (i_redirect) begin
        m_pc = i_redirect_pc; m_sq = 1'b0;
      end else if (m_sq) begin
        m_pc = m_sq_pc; m_sq = 1'b0;
      end else begin
        m_have = 1'b1; m_instr = i_iresp_data;
      end
    end else begin
      if (i_iresp_addr_ok) m_acc = 1'b1;
      if (i_redirect) begin
        m_sq = 1'b1; m_sq_pc = i_redirect_pc;
      end
    end
  end

  // Transfers actually observed on the DUT's output handshake.
  logic [63:0] log_pc[$];
  logic [31:0] log_instr[$];

  always @(negedge clk) begin
    logic exp_req, exp_out;
    exp_req = !reset && !m_acc && !m_have;
    exp_out = !reset && m_have && !i_redirect;
    chk("ireq_valid", {63'd0, o_ireq_valid}, {63'd0, exp_req});
    chk("out_valid", {63'd0, o_out_valid}, {63'd0, exp_out});
    if (exp_req) chk("ireq_addr", o_ireq_addr, m_pc);
    if (exp_out) begin
      chk("out_pc", o_out_pc, m_pc);
      chk("out_instr", {32'd0, o_out_instr}, {32'd0, m_instr});
    end
    if (o_out_valid && i_out_ready) begin
      log_pc.push_back(o_out_pc);
      log_instr.push_back(o_out_instr);
    end
  end

  // Inputs change 2 time units after the rising edge and hold for a cycle.
  task automatic drive(input logic ao, input logic dok, input logic [31:0] d,
                       input logic rdy, input logic rd, input logic [63:0] rpc);
    @(posedge clk); #2;
    i_iresp_addr_ok = ao; i_iresp_data_ok = dok; i_iresp_data = d;
    i_out_ready = rdy; i_redirect = rd; i_redirect_pc = rpc;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    i_redirect = 1'b0; i_redirect_pc = '0;
    i_iresp_addr_ok = 1'b0; i_iresp_data_ok = 1'b0; i_iresp_data = '0;
    i_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2; #1;
    chk("reset_ireq_valid", {63'd0, o_ireq_valid}, 64'd0);
    chk("reset_out_valid", {63'd0, o_out_valid}, 64'd0);
    #0 reset = 1'b0;

    // Zero-wait bus
    drive(1, 1, 32'h0000_0013, 1, 0, '0);
    chk("t1_req_valid", {63'd0, o_ireq_valid}, 64'd1);
    chk("t1_req_addr", o_ireq_addr, 64'h8000_0000);
    drive(0, 0, '0, 1, 0, '0);
    chk("t1_out_valid", {63'd0, o_out_valid}, 64'd1);
    chk("t1_out_pc", o_out_pc, 64'h8000_0000);
    chk("t1_out_instr", {32'd0, o_out_instr}, 64'h13);
    drive(1, 1, 32'h0010_0093, 0, 0, '0);
    chk("t1_next_req", o_ireq_addr, 64'h8000_0004);

    // Stall in HOLD
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, '0, 0, 0, '0);
      chk("t2_out_valid", {63'd0, o_out_valid}, 64'd1);
      chk("t2_out_pc", o_out_pc, 64'h8000_0004);
      chk("t2_out_instr", {32'd0, o_out_instr}, 64'h0010_0093);
      chk("t2_no_req", {63'd0, o_ireq_valid}, 64'd0);
    end
    // Redirect in HOLD with out_ready high: no transfer
    drive(0, 0, '0, 1, 1, 64'h8000_0000);
    chk("t5a_out_valid", {63'd0, o_out_valid}, 64'd0);

    // Delayed addr_ok with redirect while address is pending
    drive(0, 0, '0, 0, 0, '0);
    drive(0, 0, '0, 0, 1, 64'h8000_0100);
    chk("t3_addr_held", o_ireq_addr, 64'h8000_0000);
    drive(0, 0, '0, 0, 0, '0);
    drive(1, 0, '0, 0, 0, '0);
    chk("t3_addr_held2", o_ireq_addr, 64'h8000_0000);
    drive(0, 1, 32'h1234_5678, 1, 0, '0);
    chk("t3_drop", {63'd0, o_out_valid}, 64'd0);
    drive(1, 1, 32'h1111_1111, 1, 0, '0);
    chk("t3_next_req", o_ireq_addr, 64'h8000_0100);
    drive(0, 0, '0, 1, 0, '0);
    chk("t3_out_pc", o_out_pc, 64'h8000_0100);

    // Two redirects in WAIT, newest wins
    drive(1, 0, '0, 0, 0, '0);
    drive(0, 0, '0, 0, 1, 64'h8000_0100);
    drive(0, 0, '0, 0, 1, 64'h8000_0200);
    drive(0, 1, 32'hDEAD_BEEF, 1, 0, '0);
    chk("t4_no_out", {63'd0, o_out_valid}, 64'd0);
    drive(1, 1, 32'hCAFE_0001, 0, 0, '0);
    chk("t4_next_req", o_ireq_addr, 64'h8000_0200);

    // Redirect in HOLD with out_ready high
    drive(0, 0, '0, 1, 1, 64'h8000_0040);
    chk("t5_out_valid", {63'd0, o_out_valid}, 64'd0);
    // Redirect coinciding with same-cycle addr_ok/data_ok
    drive(1, 1, 32'h2222_2222, 0, 1, 64'h8000_0300);
    chk("t5_next_req", o_ireq_addr, 64'h8000_0040);
    // Misaligned target near the top of the address space
    drive(1, 1, 32'h3333_3333, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("kill_req", o_ireq_addr, 64'h8000_0300);
    drive(1, 1, 32'h4444_4444, 0, 0, '0);
    chk("wrap_req", o_ireq_addr, 64'hFFFF_FFFF_FFFF_FFFE);
    drive(0, 0, '0, 1, 0, '0);
    chk("wrap_out_pc", o_out_pc, 64'hFFFF_FFFF_FFFF_FFFE);
    drive(1, 1, '0, 0, 1, 64'h8000_0010);
    chk("wrap_next_req", o_ireq_addr, 64'h0000_0000_0000_0002);

    // Reset in WAIT with a pending redirect
    drive(1, 0, '0, 0, 0, '0);
    chk("t6_req", o_ireq_addr, 64'h8000_0010);
    drive(0, 0, '0, 0, 1, 64'h8000_0500);
    @(posedge clk); #2;
    reset = 1'b1; i_redirect = 1'b0;
    #1;
    chk("t6_reset_req", {63'd0, o_ireq_valid}, 64'd0);
    @(posedge clk); #2;
    i_iresp_data_ok = 1'b1; i_iresp_data = 32'hAAAA_AAAA;
    #1;
    chk("t6_reset_out", {63'd0, o_out_valid}, 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    i_iresp_data_ok = 1'b0;
    #1;
    chk("t6_first_req", o_ireq_addr, 64'h8000_0000);
    drive(1, 1, 32'h5555_5555, 0, 0, '0);
    drive(0, 0, '0, 1, 0, '0);
    chk("t6_no_pend", {63'd0, o_out_valid}, 64'd1);
    chk("t6_instr", {32'd0, o_out_instr}, 64'h5555_5555);
    drive(0, 0, '0, 0, 0, '0);
    @(posedge clk); #2;

    chk("log_count", 64'(log_pc.size()), 64'd4);
    if (log_pc.size() == 4) begin
      chk("log0_pc", log_pc[0], 64'h8000_0000);
      chk("log0_in", {32'd0, log_instr[0]}, 64'h13);
      chk("log1_pc", log_pc[1], 64'h8000_0100);
      chk("log1_in", {32'd0, log_instr[1]}, 64'h1111_1111);
      chk("log2_pc", log_pc[2], 64'hFFFF_FFFF_FFFF_FFFE);
      chk("log2_in", {32'd0, log_instr[2]}, 64'h4444_4444);
      chk("log3_pc", log_pc[3], 64'h8000_0000);
      chk("log3_in", {32'd0, log_instr[3]}, 64'h5555_5555);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
